wb_burst_master: RTL and testbench
==================================

# wb_burst_master

Wishbone B3 burst initiator that drives one port of the multi-port SDRAM memory controller from a simple command/stream interface. It turns a command (address, direction, burst type, length) into a registered-feedback Wishbone cycle using the controller's packed 36-bit address format, with CTI/BTE/WE in the low bits. It streams write beats in with valid/ready and read beats out as valid pulses. One instance sits in front of each controller port that needs a DMA-style client.

## Interface
Parameters:
- timeout_cycles, 255: wait cycles with no ack before a cycle is aborted; used only with the timeout macro; range 1..1023.

Ports:
- wb_clk  in  1  single clock for all logic
- wb_rst_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  high in IDLE
- cmd_we  in  1  1 = write, 0 = read
- cmd_adr  in  30  starting word address
- cmd_bte  in  2  00 linear, 01 wrap4, 10 wrap8, 11 wrap16
- cmd_len  in  4  beats−1; used only for linear bursts
- wr_data  in  32  write beat data
- wr_sel  in  4  write beat byte selects
- wr_valid  in  1  write beat offered
- wr_ready  out  1  write beat accepted when wr_valid & wr_ready
- rd_data  out  32  read beat data
- rd_valid  out  1  one-cycle pulse per read beat; no backpressure
- done  out  1  one-cycle pulse at cycle end
- err  out  1  valid with done; 1 = aborted
- wb_adr_o  out  36  [35:6] word address, [5] WE, [4:3] BTE, [2:0] CTI
- wb_dat_o  out  36  [35:4] data, [3:0] byte selects
- wb_cyc_o  out  1  cycle
- wb_stb_o  out  1  strobe
- wb_dat_i  in  32  read data
- wb_ack_i  in  1  acknowledge

## Operation
- FSM states: IDLE, READ, WRITE.
- Accept: IDLE with cmd_valid. The command is latched and the FSM goes to READ or WRITE by cmd_we.
- Beat count N:
  - wrap4/8/16: N = 4/8/16; cmd_len is ignored.
  - linear: N = cmd_len+1.
- CTI:
  - N = 1: classic (000).
  - Otherwise 010 on every beat except the last, which carries 111.
  - For wrap bursts the BTE field carries cmd_bte. For linear bursts, and for classic (N = 1), BTE = 00.
- Address advance on each ack:
  - linear: word address +1, modulo 2^30.
  - wrap4/8/16: only address bits [1:0], [2:0] or [3:0] increment, wrapping within the block; upper bits are held.
- READ:
  - cyc and stb go high the cycle after accept and stay high until the final ack.
  - Each ack registers wb_dat_i to rd_data, and rd_valid pulses on the next cycle.
- WRITE:
  - cyc goes high the cycle after accept.
  - The beat register holds {wr_data, wr_sel} and drives wb_dat_o. stb equals "beat register full".
  - wr_ready = ~full | (stb & ack), asserted only while beats remain to be loaded.
  - If wr_valid is low, stb drops (wait state) and cyc stays high.
- End: the cycle after the final ack, cyc, stb and WE go low, done pulses with err = 0, and the FSM returns to IDLE.
- An ack while stb is low is ignored.
- Reset at any time forces IDLE and clears all outputs immediately; the cycle is not completed.

## Timing
- Reset values:
  - cmd_ready = 1.
  - All other outputs 0, including wb_adr_o and wb_dat_o.
- All Wishbone outputs are registered.
- Read latency: ack edge to rd_valid = 1 cycle.
- Accept-to-first-beat latency:
  - Read: cyc/stb high 1 cycle after accept.
  - Write: stb high 1 cycle after the first wr_valid & wr_ready.
  - The first beat's wr_ready can assert in the accept+1 cycle.
- Back-to-back: an ack with the next beat ready keeps stb high with no bubble, and the address/CTI update in the same edge.
- Minimum gap between commands: done cycle, then IDLE for one cycle, so cmd_ready rises the cycle after done.

## Configuration
- VERSATILE_WB_MASTER_TIMEOUT_EN defined:
  - A 10-bit counter clears on every ack and on every cycle with stb low, and increments while stb is high without ack.
  - At timeout_cycles the FSM forces cyc/stb low on the next edge, pulses done with err = 1, and returns to IDLE.
  - Unsent write beats are not consumed.
- VERSATILE_WB_MASTER_TIMEOUT_EN undefined: no counter, err tied 0, and the master waits for ack indefinitely.

## Test plan
- Classic read:
  - Stimulus: cmd_adr=0x100, cmd_len=0, linear; ack after 2 wait cycles with dat_i=0xDEADBEEF.
  - Required: wb_adr_o[35:6]=0x100, [5:0]=000000; one rd_valid with 0xDEADBEEF; done with err=0.
- Wrap8 write:
  - Stimulus: cmd_adr=0x1D, cmd_we=1, eight wr_valid beats with ack every cycle.
  - Required: address sequence 1D,1E,1F,18,19,1A,1B,1C; CTI 010×7 then 111; BTE=10; no stb bubbles.
- Linear read, 16 beats:
  - Stimulus: cmd_adr=0x3FFFFFFE.
  - Required: address wraps to 0 after 0x3FFFFFFF; 16 rd_valid pulses; cyc low the cycle after the 16th ack.
- Write-data starvation:
  - Stimulus: wr_valid low for 3 cycles mid-burst.
  - Required: stb low, cyc high for 3 cycles; burst resumes at the correct address.
- Reset mid-burst:
  - Stimulus: wb_rst_n low during beat 3.
  - Required: cyc/stb 0 immediately without a clock; cmd_ready 1 after release; no done.
- Timeout (macro on, timeout_cycles=4):
  - Stimulus: no ack is ever returned.
  - Required: cyc drops 5 cycles after stb rises; done=1 with err=1.

Source files
------------

// File: rtl/wb_burst_master.sv
// Wishbone B3 burst initiator: command + write stream in, registered-feedback burst out, read beats as pulses.
// Optional ack timeout/abort is built when VERSATILE_WB_MASTER_TIMEOUT_EN is defined.
module wb_burst_master #(
  parameter int timeout_cycles = 255
) (
  input  logic        wb_clk,
  input  logic        wb_rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [29:0] cmd_adr,
  input  logic [1:0]  cmd_bte,
  input  logic [3:0]  cmd_len,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_sel,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        done,
  output logic        err,
  output logic [35:0] wb_adr_o,
  output logic [35:0] wb_dat_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i
);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  state_t      r_state, w_state_nxt;
  logic [29:0] r_adr;
  logic        r_we;
  logic [1:0]  r_bte;
  logic [2:0]  r_cti;
  logic [35:0] r_dat;
  logic        r_cyc, r_stb;
  logic [3:0]  r_left;   // acks still owed after the beat on the bus
  logic [4:0]  r_load;   // write beats not yet taken from the stream
  logic [31:0] r_rd_data;
  logic        r_rd_valid, r_done;

  logic        w_accept, w_ack, w_last, w_load, w_abort;
  logic [3:0]  w_len;
  logic [29:0] w_mask, w_adr_inc, w_adr_nxt;

  // Beats-1 for the incoming command; wrap bursts ignore cmd_len.
  always_comb begin
    case (cmd_bte)
      2'b01:   w_len = 4'd3;
      2'b10:   w_len = 4'd7;
      2'b11:   w_len = 4'd15;
      default: w_len = cmd_len;
    endcase
  end

  // Linear uses an all-ones mask, so one expression covers every burst type.
  always_comb begin
    case (r_bte)
      2'b01:   w_mask = 30'h3;
      2'b10:   w_mask = 30'h7;
      2'b11:   w_mask = 30'hF;
      default: w_mask = '1;
    endcase
  end

  assign w_adr_inc = r_adr + 30'd1;
  assign w_adr_nxt = (r_adr & ~w_mask) | (w_adr_inc & w_mask);

`ifdef VERSATILE_WB_MASTER_TIMEOUT_EN
  logic [9:0] r_tmo;
  logic       r_err;

  assign w_abort = r_stb & ~wb_ack_i & (r_tmo == 10'(timeout_cycles));

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_tmo <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= w_abort;
      if (!r_stb || wb_ack_i) r_tmo <= '0;
      else                    r_tmo <= r_tmo + 10'd1;
    end
  end

  assign err = r_err;
`else
  logic [9:0] w_unused_tmo;
  assign w_unused_tmo = 10'(timeout_cycles);
  assign w_abort      = 1'b0;
  assign err          = 1'b0;
`endif

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) r_state <= IDLE;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:        if (w_accept) w_state_nxt = cmd_we ? WRITE : READ;
      READ, WRITE: if (w_last || w_abort) w_state_nxt = IDLE;
      default:     w_state_nxt = IDLE;
    endcase
  end

  // r_done keeps cmd_ready low through the done cycle.
  always_comb begin
    cmd_ready = (r_state == IDLE) & ~r_done;
    w_accept  = cmd_valid & cmd_ready;
    w_ack     = r_stb & wb_ack_i;
    w_last    = w_ack & (r_left == 4'd0);
    wr_ready  = (r_state == WRITE) & (r_load != 5'd0) & (~r_stb | w_ack);
    w_load    = wr_valid & wr_ready;
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_adr      <= '0;
      r_we       <= 1'b0;
      r_bte      <= '0;
      r_cti      <= '0;
      r_dat      <= '0;
      r_cyc      <= 1'b0;
      r_stb      <= 1'b0;
      r_left     <= '0;
      r_load     <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      r_done     <= 1'b0;
      if (w_accept) begin
        r_adr  <= cmd_adr;
        r_we   <= cmd_we;
        r_bte  <= cmd_bte;
        r_cti  <= (w_len == 4'd0) ? CTI_CLASSIC : CTI_INC;
        r_left <= w_len;
        r_load <= cmd_we ? ({1'b0, w_len} + 5'd1) : 5'd0;
        r_cyc  <= 1'b1;
        r_stb  <= ~cmd_we;
      end else if (w_abort) begin
        r_cyc  <= 1'b0;
        r_stb  <= 1'b0;
        r_we   <= 1'b0;
        r_load <= '0;
        r_done <= 1'b1;
      end else if (w_last) begin
        r_cyc  <= 1'b0;
        r_stb  <= 1'b0;
        r_we   <= 1'b0;
        r_done <= 1'b1;
      end else begin
        if (w_ack) begin
          r_adr  <= w_adr_nxt;
          r_left <= r_left - 4'd1;
          r_cti  <= (r_left == 4'd1) ? CTI_END : CTI_INC;
        end
        // Write strobe tracks the beat register: refilled on load, emptied by ack.
        if (r_we) r_stb <= w_load | (r_stb & ~w_ack);
        if (w_load) begin
          r_dat  <= {wr_data, wr_sel};
          r_load <= r_load - 5'd1;
        end
      end
      if (w_ack && !r_we) begin
        r_rd_data  <= wb_dat_i;
        r_rd_valid <= 1'b1;
      end
    end
  end

  assign wb_adr_o = {r_adr, r_we, r_bte, r_cti};
  assign wb_dat_o = r_dat;
  assign wb_cyc_o = r_cyc;
  assign wb_stb_o = r_stb;
  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign done     = r_done;

endmodule

// File: tb/tb_wb_burst_master.sv
// Scoreboard bench for wb_burst_master: a Wishbone slave/monitor records beats, tasks compare against expectations.
module tb_wb_burst_master;
  logic        wb_clk = 1'b0;
  logic        wb_rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_we = 1'b0;
  logic [29:0] cmd_adr = '0;
  logic [1:0]  cmd_bte = '0;
  logic [3:0]  cmd_len = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_sel = '0;
  logic        wr_valid = 1'b0;
  logic        cmd_ready, wr_ready, rd_valid, done, err, wb_cyc_o, wb_stb_o;
  logic [31:0] rd_data;
  logic [35:0] wb_adr_o, wb_dat_o;
  logic [31:0] wb_dat_i = '0;
  logic        wb_ack_i = 1'b0;

  always #5 wb_clk = ~wb_clk;

  wb_burst_master #(.timeout_cycles(4)) dut (
    .wb_clk(wb_clk), .wb_rst_n(wb_rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_adr(cmd_adr),
    .cmd_bte(cmd_bte), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_sel(wr_sel), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err(err),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
  );

  int chk_cnt = 0, pass_cnt = 0;

  logic [35:0] q_exp_adr[$], q_exp_dat[$], q_obs_adr[$], q_obs_dat[$], q_wr[$];
  logic [31:0] q_exp_rd[$], q_obs_rd[$];

  int   mcyc = 0, done_cnt = 0, done_cyc = 0, ack_cyc = 0, rd_cyc = 0;
  int   bubbles = 0, stb_rise = 0, cyc_fall = 0;
  logic done_err = 1'b0, cyc_at_done = 1'b0, seen_stb = 1'b0, prev_stb = 1'b0, prev_cyc = 1'b0;
  int   s_wait = 0, s_wcnt = 0, s_beat = 0, wr_loaded = 0, s_gap_beat = 99, s_gap_left = 0;
  logic s_noack = 1'b0;
  logic [31:0] s_dbase = '0;

  // Slave, write-stream source and monitor, all acting on the falling edge.
  always @(negedge wb_clk) begin
    mcyc++;
    if (rd_valid) begin
      q_obs_rd.push_back(rd_data);
      rd_cyc = mcyc;
    end
    if (done) begin
      done_cnt++;
      done_err    = err;
      done_cyc    = mcyc;
      cyc_at_done = wb_cyc_o;
    end
    if (wb_cyc_o && !wb_stb_o && seen_stb) bubbles++;
    if (wb_stb_o && !prev_stb) stb_rise = mcyc;
    if (!wb_cyc_o && prev_cyc) cyc_fall = mcyc;
    seen_stb = wb_cyc_o && (seen_stb || wb_stb_o);
    prev_stb = wb_stb_o;
    prev_cyc = wb_cyc_o;

    wb_ack_i = 1'b0;
    if (wb_rst_n && wb_cyc_o && wb_stb_o && !s_noack) begin
      if (s_wcnt >= s_wait) begin
        wb_ack_i = 1'b1;
        wb_dat_i = s_dbase + 32'(s_beat);
        s_beat++;
        s_wcnt = 0;
        ack_cyc = mcyc;
        q_obs_adr.push_back(wb_adr_o);
        q_obs_dat.push_back(wb_dat_o);
      end else begin
        s_wcnt++;
      end
    end

    if (s_gap_left > 0 && wr_loaded == s_gap_beat) begin
      wr_valid = 1'b0;
      s_gap_left--;
    end else if (q_wr.size() > 0) begin
      wr_valid = 1'b1;
      {wr_data, wr_sel} = q_wr[0];
    end else begin
      wr_valid = 1'b0;
    end
    #1;
    if (wr_valid && wr_ready) begin
      void'(q_wr.pop_front());
      wr_loaded++;
    end
  end

  task automatic tick();
    @(negedge wb_clk);
    #3;
  endtask

  task automatic clear_sb();
    q_exp_adr.delete(); q_exp_dat.delete(); q_obs_adr.delete(); q_obs_dat.delete();
    q_wr.delete(); q_exp_rd.delete(); q_obs_rd.delete();
    s_beat = 0; s_wcnt = 0; wr_loaded = 0; bubbles = 0;
    s_gap_beat = 99; s_gap_left = 0; s_noack = 1'b0;
  endtask

  task automatic issue(input logic we, input logic [29:0] a, input logic [1:0] bte, input logic [3:0] len);
    cmd_we = we; cmd_adr = a; cmd_bte = bte; cmd_len = len; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int d0;
    d0 = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      if (done_cnt != d0) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    wb_rst_n = 1'b0;
    tick(); tick();
    chk_cnt++; if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); else pass_cnt++;
    chk_cnt++; if ({wb_cyc_o, wb_stb_o} !== 2'b00) $display("FAIL reset_cyc_stb got %b want 00", {wb_cyc_o, wb_stb_o}); else pass_cnt++;
    chk_cnt++; if (wb_adr_o !== 36'h0) $display("FAIL reset_adr got %h want 0", wb_adr_o); else pass_cnt++;
    chk_cnt++; if (wb_dat_o !== 36'h0) $display("FAIL reset_dat got %h want 0", wb_dat_o); else pass_cnt++;
    chk_cnt++; if ({rd_valid, done, err, wr_ready} !== 4'b0) $display("FAIL reset_flags got %b want 0000", {rd_valid, done, err, wr_ready}); else pass_cnt++;
    chk_cnt++; if (rd_data !== 32'h0) $display("FAIL reset_rd_data got %h want 0", rd_data); else pass_cnt++;
    wb_rst_n = 1'b1;
    tick();
    chk_cnt++; if (cmd_ready !== 1'b1) $display("FAIL idle_cmd_ready got %b want 1", cmd_ready); else pass_cnt++;
  endtask

  task automatic test_classic_read();
    bit ok;
    logic [35:0] ea, oa;
    logic [31:0] ed, od;
    clear_sb();
    s_wait = 2; s_dbase = 32'hDEADBEEF;
    q_exp_adr.push_back({30'h100, 1'b0, 2'b00, 3'b000});
    q_exp_rd.push_back(32'hDEADBEEF);
    issue(1'b0, 30'h100, 2'b00, 4'd0);
    chk_cnt++; if ({wb_cyc_o, wb_stb_o} !== 2'b11) $display("FAIL classic_first_stb got %b want 11", {wb_cyc_o, wb_stb_o}); else pass_cnt++;
    wait_done(40, ok);
    chk_cnt++; if (!ok) $display("FAIL classic_done_timeout got none want done"); else pass_cnt++;
    chk_cnt++; if (done_err !== 1'b0) $display("FAIL classic_err got %b want 0", done_err); else pass_cnt++;
    chk_cnt++; if (cmd_ready !== 1'b0) $display("FAIL classic_ready_in_done got %b want 0", cmd_ready); else pass_cnt++;
    chk_cnt++; if (rd_cyc !== ack_cyc + 1) $display("FAIL classic_rd_latency got %0d want %0d", rd_cyc - ack_cyc, 1); else pass_cnt++;
    chk_cnt++; if (q_obs_adr.size() != q_exp_adr.size()) $display("FAIL classic_beats got %0d want %0d", q_obs_adr.size(), q_exp_adr.size()); else pass_cnt++;
    while (q_exp_adr.size() > 0 && q_obs_adr.size() > 0) begin
      ea = q_exp_adr.pop_front(); oa = q_obs_adr.pop_front();
      chk_cnt++; if (oa !== ea) $display("FAIL classic_adr got %h want %h", oa, ea); else pass_cnt++;
    end
    chk_cnt++; if (q_obs_rd.size() != q_exp_rd.size()) $display("FAIL classic_rd_count got %0d want %0d", q_obs_rd.size(), q_exp_rd.size()); else pass_cnt++;
    while (q_exp_rd.size() > 0 && q_obs_rd.size() > 0) begin
      ed = q_exp_rd.pop_front(); od = q_obs_rd.pop_front();
      chk_cnt++; if (od !== ed) $display("FAIL classic_rd_data got %h want %h", od, ed); else pass_cnt++;
    end
    tick();
    chk_cnt++; if (cmd_ready !== 1'b1) $display("FAIL classic_ready_after got %b want 1", cmd_ready); else pass_cnt++;
  endtask

  task automatic test_wrap8_write();
    bit ok;
    logic [29:0] seq [8];
    logic [35:0] d, ea, oa;
    clear_sb();
    s_wait = 0;
    seq = '{30'h1D, 30'h1E, 30'h1F, 30'h18, 30'h19, 30'h1A, 30'h1B, 30'h1C};
    for (int i = 0; i < 8; i++) begin
      d = {32'hC0DE0000 + 32'(i), 4'hF ^ 4'(i)};
      q_wr.push_back(d);
      q_exp_dat.push_back(d);
      q_exp_adr.push_back({seq[i], 1'b1, 2'b10, (i == 7) ? 3'b111 : 3'b010});
    end
    issue(1'b1, 30'h1D, 2'b10, 4'd2);
    wait_done(60, ok);
    chk_cnt++; if (!ok) $display("FAIL wrap8_done_timeout got none want done"); else pass_cnt++;
    chk_cnt++; if (done_err !== 1'b0) $display("FAIL wrap8_err got %b want 0", done_err); else pass_cnt++;
    chk_cnt++; if (bubbles != 0) $display("FAIL wrap8_bubbles got %0d want 0", bubbles); else pass_cnt++;
    chk_cnt++; if (q_obs_adr.size() != 8) $display("FAIL wrap8_beats got %0d want 8", q_obs_adr.size()); else pass_cnt++;
    while (q_exp_adr.size() > 0 && q_obs_adr.size() > 0) begin
      ea = q_exp_adr.pop_front(); oa = q_obs_adr.pop_front();
      chk_cnt++; if (oa !== ea) $display("FAIL wrap8_adr got %h want %h", oa, ea); else pass_cnt++;
    end
    while (q_exp_dat.size() > 0 && q_obs_dat.size() > 0) begin
      ea = q_exp_dat.pop_front(); oa = q_obs_dat.pop_front();
      chk_cnt++; if (oa !== ea) $display("FAIL wrap8_dat got %h want %h", oa, ea); else pass_cnt++;
    end
    tick();
  endtask

  task automatic test_linear_read16();
    bit ok;
    logic [29:0] a;
    logic [35:0] ea, oa;
    logic [31:0] ed, od;
    clear_sb();
    s_wait = 0; s_dbase = 32'h12340000;
    for (int i = 0; i < 16; i++) begin
      a = 30'h3FFFFFFE + 30'(i);
      q_exp_adr.push_back({a, 1'b0, 2'b00, (i == 15) ? 3'b111 : 3'b010});
      q_exp_rd.push_back(32'h12340000 + 32'(i));
    end
    issue(1'b0, 30'h3FFFFFFE, 2'b00, 4'd15);
    wait_done(100, ok);
    chk_cnt++; if (!ok) $display("FAIL lin16_done_timeout got none want done"); else pass_cnt++;
    chk_cnt++; if (done_cyc !== ack_cyc + 1) $display("FAIL lin16_done_after_ack got %0d want 1", done_cyc - ack_cyc); else pass_cnt++;
    chk_cnt++; if (cyc_at_done !== 1'b0) $display("FAIL lin16_cyc_at_done got %b want 0", cyc_at_done); else pass_cnt++;
    chk_cnt++; if (q_obs_rd.size() != 16) $display("FAIL lin16_rd_count got %0d want 16", q_obs_rd.size()); else pass_cnt++;
    while (q_exp_adr.size() > 0 && q_obs_adr.size() > 0) begin
      ea = q_exp_adr.pop_front(); oa = q_obs_adr.pop_front();
      chk_cnt++; if (oa !== ea) $display("FAIL lin16_adr got %h want %h", oa, ea); else pass_cnt++;
    end
    while (q_exp_rd.size() > 0 && q_obs_rd.size() > 0) begin
      ed = q_exp_rd.pop_front(); od = q_obs_rd.pop_front();
      chk_cnt++; if (od !== ed) $display("FAIL lin16_rd_data got %h want %h", od, ed); else pass_cnt++;
    end
    tick();
  endtask

  task automatic test_wr_starve();
    bit ok;
    logic [35:0] d, ea, oa;
    clear_sb();
    s_wait = 0; s_gap_beat = 3; s_gap_left = 3;
    for (int i = 0; i < 6; i++) begin
      d = {32'h5A000000 + 32'(i * 3), 4'(i + 1)};
      q_wr.push_back(d);
      q_exp_dat.push_back(d);
      q_exp_adr.push_back({30'h40 + 30'(i), 1'b1, 2'b00, (i == 5) ? 3'b111 : 3'b010});
    end
    issue(1'b1, 30'h40, 2'b00, 4'd5);
    wait_done(60, ok);
    chk_cnt++; if (!ok) $display("FAIL starve_done_timeout got none want done"); else pass_cnt++;
    chk_cnt++; if (bubbles != 3) $display("FAIL starve_bubbles got %0d want 3", bubbles); else pass_cnt++;
    chk_cnt++; if (q_obs_adr.size() != 6) $display("FAIL starve_beats got %0d want 6", q_obs_adr.size()); else pass_cnt++;
    while (q_exp_adr.size() > 0 && q_obs_adr.size() > 0) begin
      ea = q_exp_adr.pop_front(); oa = q_obs_adr.pop_front();
      chk_cnt++; if (oa !== ea) $display("FAIL starve_adr got %h want %h", oa, ea); else pass_cnt++;
    end
    while (q_exp_dat.size() > 0 && q_obs_dat.size() > 0) begin
      ea = q_exp_dat.pop_front(); oa = q_obs_dat.pop_front();
      chk_cnt++; if (oa !== ea) $display("FAIL starve_dat got %h want %h", oa, ea); else pass_cnt++;
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int d0;
    clear_sb();
    s_wait = 0; s_dbase = 32'h0;
    issue(1'b0, 30'h200, 2'b00, 4'd7);
    for (int i = 0; i < 20 && s_beat < 2; i++) tick();
    tick();
    chk_cnt++; if ({wb_cyc_o, wb_stb_o} !== 2'b11) $display("FAIL rstmid_busy got %b want 11", {wb_cyc_o, wb_stb_o}); else pass_cnt++;
    d0 = done_cnt;
    wb_rst_n = 1'b0;
    #1;
    chk_cnt++; if ({wb_cyc_o, wb_stb_o} !== 2'b00) $display("FAIL rstmid_async got %b want 00", {wb_cyc_o, wb_stb_o}); else pass_cnt++;
    chk_cnt++; if (wb_adr_o !== 36'h0) $display("FAIL rstmid_adr got %h want 0", wb_adr_o); else pass_cnt++;
    tick(); tick();
    wb_rst_n = 1'b1;
    tick();
    chk_cnt++; if (cmd_ready !== 1'b1) $display("FAIL rstmid_ready got %b want 1", cmd_ready); else pass_cnt++;
    tick(); tick();
    chk_cnt++; if (done_cnt != d0) $display("FAIL rstmid_no_done got %0d want %0d", done_cnt, d0); else pass_cnt++;
    chk_cnt++; if (wb_cyc_o !== 1'b0) $display("FAIL rstmid_idle_cyc got %b want 0", wb_cyc_o); else pass_cnt++;
  endtask

`ifdef VERSATILE_WB_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    clear_sb();
    s_noack = 1'b1;
    issue(1'b0, 30'h55, 2'b00, 4'd0);
    wait_done(40, ok);
    chk_cnt++; if (!ok) $display("FAIL tmo_done_timeout got none want done"); else pass_cnt++;
    chk_cnt++; if (done_err !== 1'b1) $display("FAIL tmo_err got %b want 1", done_err); else pass_cnt++;
    chk_cnt++; if (cyc_fall - stb_rise != 5) $display("FAIL tmo_latency got %0d want 5", cyc_fall - stb_rise); else pass_cnt++;
    chk_cnt++; if (cyc_at_done !== 1'b0) $display("FAIL tmo_cyc_at_done got %b want 0", cyc_at_done); else pass_cnt++;
    chk_cnt++; if (q_obs_rd.size() != 0) $display("FAIL tmo_rd_count got %0d want 0", q_obs_rd.size()); else pass_cnt++;
    s_noack = 1'b0;
    tick();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_classic_read();
    test_wrap8_write();
    test_linear_read16();
    test_wr_starve();
    test_reset_mid();
`ifdef VERSATILE_WB_MASTER_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
